// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: drives fixed-width set/reset pulses into a bank of SR
// flip-flops from a valid/ready request that carries a channel mask and a target value.
// Build option: define SR_PULSE_VERIFY_EN to compile in q feedback checking
// with a timeout. This adds the CHECK state, the timeout counter and the err strobe.
// Without it, done follows the pulse directly, q_fb is ignored and err is tied to 0.
`timescale 1ns/1ps

module sr_pulse_driver #(
    parameter int WIDTH     = 4,
    parameter int PULSE_CYC = 2,
    parameter int TIMEOUT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0] req_val,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int PCNT_W = $clog2(PULSE_CYC + 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYC - 1);

`ifdef SR_PULSE_VERIFY_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DONE  = 2'd3
    } state_t;
`endif

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  mask_reg, mask_next;
    logic [WIDTH-1:0]  val_reg, val_next;
    logic [PCNT_W-1:0] pcnt_reg, pcnt_next;
    logic [WIDTH-1:0]  s_reg, s_next;
    logic [WIDTH-1:0]  r_reg, r_next;
    logic              done_reg, done_next;
    logic              pulse_en;

`ifdef SR_PULSE_VERIFY_EN
    logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
    logic              err_reg, err_next;
    logic              q_match;

    // Compare only the channels this request drives.
    assign q_match = ((q_fb & mask_reg) == (val_reg & mask_reg));
`else
    // q_fb and TIMEOUT are kept only so both builds have the same ports and parameters.
    logic unused_cfg;
    assign unused_cfg = ^{q_fb, TIMEOUT};
`endif

    // State, latched request, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            mask_reg  <= '0;
            val_reg   <= '0;
            pcnt_reg  <= '0;
            s_reg     <= '0;
            r_reg     <= '0;
            done_reg  <= 1'b0;
`ifdef SR_PULSE_VERIFY_EN
            tcnt_reg  <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            val_reg   <= val_next;
            pcnt_reg  <= pcnt_next;
            s_reg     <= s_next;
            r_reg     <= r_next;
            done_reg  <= done_next;
`ifdef SR_PULSE_VERIFY_EN
            tcnt_reg  <= tcnt_next;
            err_reg   <= err_next;
`endif
        end
    end

    // Next-state logic. The outputs are computed from the state being entered,
    // so they line up with that state and need no extra cycle.
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        val_next   = val_reg;
        pcnt_next  = pcnt_reg;
`ifdef SR_PULSE_VERIFY_EN
        tcnt_next  = tcnt_reg;
        err_next   = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    mask_next = req_mask;
                    val_next  = req_val;
                    pcnt_next = '0;
`ifdef SR_PULSE_VERIFY_EN
                    tcnt_next = '0;
`endif
                    // An empty mask has nothing to pulse, so it completes at once.
                    state_next = (req_mask == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (pcnt_reg == PCNT_LAST) begin
                    pcnt_next = '0;
`ifdef SR_PULSE_VERIFY_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
`endif
                end else begin
                    pcnt_next = pcnt_reg + 1'b1;
                end
            end
`ifdef SR_PULSE_VERIFY_EN
            ST_CHECK: begin
                if (q_match) begin
                    state_next = ST_DONE;
                end else if (tcnt_reg == TCNT_LAST) begin
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pulse and done strobes follow the state being entered.
    always_comb begin
        pulse_en  = (state_next == ST_PULSE);
        done_next = (state_next == ST_DONE);
    end

    // Per-channel encoding. Each channel gets either s or r, never both,
    // because the two terms use opposite polarities of the same value bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            assign s_next[gi] = pulse_en & mask_next[gi] &  val_next[gi];
            assign r_next[gi] = pulse_en & mask_next[gi] & ~val_next[gi];
        end
    endgenerate

    assign s         = s_reg;
    assign r         = r_reg;
    assign done      = done_reg;
    assign req_ready = (state_reg == ST_IDLE);
`ifdef SR_PULSE_VERIFY_EN
    assign busy      = (state_reg == ST_PULSE) || (state_reg == ST_CHECK);
    assign err       = err_reg;
`else
    assign busy      = (state_reg == ST_PULSE);
    assign err       = 1'b0;
`endif

endmodule
